// File: rtl/pulse_req_scheduler.sv
// Round-robin scheduler: captures per-requester request pulses into pending
// flags and serializes them onto one shared transmitter using a start/done
// handshake with a done-timeout and a forced idle gap between transactions.
module pulse_req_scheduler #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned GAP_CYC = 2,
    localparam int unsigned IDW    = $clog2(N_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [N_REQ-1:0] req_pulse_i,
    input  logic             tx_done_i,
    output logic             tx_start_o,
    output logic [IDW-1:0]   tx_sel_o,
    output logic             busy_o,
    output logic [N_REQ-1:0] pending_o,
    output logic [N_REQ-1:0] req_ovf_o,
    output logic             timeout_err_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StGap} state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] ovf_q, ovf_d;
    logic [N_REQ-1:0] clr;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [IDW-1:0]   sel_q, sel_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             tmo_q, tmo_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic [15:0]      gap_cnt_q, gap_cnt_d;
    logic [IDW-1:0]   cand_idx;
    logic [IDW-1:0]   win_idx;
    logic             win_found;

    // Round-robin winner: first pending bit after rr_q, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand_idx = IDW'((32'(rr_q) + k) % N_REQ);
            if (!win_found && pending_q[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state, handshake and counter logic.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_d       = rr_q;
        start_d    = 1'b0;
        tmo_d      = 1'b0;
        wait_cnt_d = wait_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        clr        = '0;
        case (state_q)
            StIdle: begin
                if (enable_i && win_found) begin
                    state_d       = StIssue;
                    sel_d         = win_idx;
                    rr_d          = win_idx;
                    clr[win_idx]  = 1'b1;
                    start_d       = 1'b1;
                end
            end
            StIssue: begin
                state_d    = StWait;
                wait_cnt_d = '0;
            end
            StWait: begin
                // A done arriving on the expiry cycle still counts as success.
                if (tx_done_i || (wait_cnt_q == 16'(TIMEOUT - 1))) begin
                    state_d   = (GAP_CYC == 0) ? StIdle : StGap;
                    gap_cnt_d = '0;
                    tmo_d     = !tx_done_i;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            StGap: begin
                if (gap_cnt_q == 16'(GAP_CYC - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Set wins over the issue-clear; a pulse on an uncleared pending bit is dropped.
        pending_d = (pending_q & ~clr) | req_pulse_i;
        ovf_d     = req_pulse_i & pending_q & ~clr;
        busy_d    = (state_d != StIdle);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            ovf_q      <= '0;
            rr_q       <= IDW'(N_REQ - 1);
            sel_q      <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
            wait_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            ovf_q      <= ovf_d;
            rr_q       <= rr_d;
            sel_q      <= sel_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
            wait_cnt_q <= wait_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign tx_start_o    = start_q;
    assign tx_sel_o      = sel_q;
    assign busy_o        = busy_q;
    assign pending_o     = pending_q;
    assign req_ovf_o     = ovf_q;
    assign timeout_err_o = tmo_q;

endmodule

// File: tb/tb_pulse_req_scheduler.sv
// Directed bench for pulse_req_scheduler (N_REQ=4, TIMEOUT=200, GAP_CYC=2).
module tb_pulse_req_scheduler;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       enable_i;
    logic [3:0] req_pulse_i;
    logic       tx_done_i;
    logic       tx_start_o;
    logic [1:0] tx_sel_o;
    logic       busy_o;
    logic [3:0] pending_o;
    logic [3:0] req_ovf_o;
    logic       timeout_err_o;

    int n_cmp  = 0;
    int n_fail = 0;

    pulse_req_scheduler #(
        .N_REQ  (4),
        .TIMEOUT(200),
        .GAP_CYC(2)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .req_pulse_i  (req_pulse_i),
        .tx_done_i    (tx_done_i),
        .tx_start_o   (tx_start_o),
        .tx_sel_o     (tx_sel_o),
        .busy_o       (busy_o),
        .pending_o    (pending_o),
        .req_ovf_o    (req_ovf_o),
        .timeout_err_o(timeout_err_o)
    );

    always #5 clk_i = ~clk_i;

    // {start, sel[1:0], busy, pending[3:0], ovf[3:0], tmo}
    logic [12:0] obus;
    assign obus = {tx_start_o, tx_sel_o, busy_o, pending_o, req_ovf_o, timeout_err_o};

    typedef struct {
        logic [3:0]  req;
        logic        en;
        logic        done;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input logic [3:0] req, input logic en, input logic done,
                              input logic start, input logic [1:0] sel, input logic busy,
                              input logic [3:0] pend, input logic [3:0] ovf, input logic tmo);
        vec_t r;
        r.req  = req;
        r.en   = en;
        r.done = done;
        r.exp  = {start, sel, busy, pend, ovf, tmo};
        vecs.push_back(r);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Finish an in-flight transaction that has just entered ISSUE.
    task automatic finish_txn();
        tick();                 // WAIT
        tx_done_i = 1'b1;
        tick();                 // GAP
        tx_done_i = 1'b0;
        tick();                 // GAP
        tick();                 // IDLE
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] pend;
        logic       early;

        // Round-robin from reset: all four requesters, done on first WAIT cycle.
        pend = 4'b1111;
        v(4'b1111, 1, 0, 0, 0, 0, 4'b1111, 0, 0);
        for (int g = 0; g < 4; g++) begin
            pend[g] = 1'b0;
            v(0, 1, 0, 1, 2'(g), 1, pend, 0, 0);   // ISSUE
            v(0, 1, 0, 0, 2'(g), 1, pend, 0, 0);   // WAIT
            v(0, 1, 1, 0, 2'(g), 1, pend, 0, 0);   // done -> GAP
            v(0, 1, 0, 0, 2'(g), 1, pend, 0, 0);   // GAP
            v(0, 1, 0, 0, 2'(g), 0, pend, 0, 0);   // IDLE
        end
        // Single request to requester 2.
        v(4'b0100, 1, 0, 0, 3, 0, 4'b0100, 0, 0);
        v(0, 1, 0, 1, 2, 1, 0, 0, 0);
        v(0, 1, 0, 0, 2, 1, 0, 0, 0);
        v(0, 1, 1, 0, 2, 1, 0, 0, 0);
        v(0, 1, 0, 0, 2, 1, 0, 0, 0);
        v(0, 1, 0, 0, 2, 0, 0, 0, 0);
        // Overflow on requester 1 while disabled; stray done in IDLE ignored.
        v(4'b0010, 0, 0, 0, 2, 0, 4'b0010, 0, 0);
        v(0, 0, 1, 0, 2, 0, 4'b0010, 0, 0);
        v(0, 0, 0, 0, 2, 0, 4'b0010, 0, 0);
        v(4'b0010, 0, 0, 0, 2, 0, 4'b0010, 4'b0010, 0);
        v(0, 0, 0, 0, 2, 0, 4'b0010, 0, 0);
        v(0, 1, 0, 1, 1, 1, 0, 0, 0);
        v(0, 1, 0, 0, 1, 1, 0, 0, 0);
        v(0, 1, 1, 0, 1, 1, 0, 0, 0);
        v(0, 1, 0, 0, 1, 1, 0, 0, 0);
        v(0, 1, 0, 0, 1, 0, 0, 0, 0);
        v(0, 1, 0, 0, 1, 0, 0, 0, 0);

        rst_ni      = 1'b0;
        enable_i    = 1'b0;
        req_pulse_i = '0;
        tx_done_i   = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        chk("reset_state", 32'(obus), 32'h0);

        foreach (vecs[i]) begin
            req_pulse_i = vecs[i].req;
            enable_i    = vecs[i].en;
            tx_done_i   = vecs[i].done;
            tick();
            chk($sformatf("vec%0d", i), 32'(obus), 32'(vecs[i].exp));
        end
        req_pulse_i = '0;
        tx_done_i   = 1'b0;
        enable_i    = 1'b1;

        // Timeout: requesters 0 and 2 pending, rr points at 1 -> 2 wins first.
        req_pulse_i = 4'b0101;
        tick();
        req_pulse_i = '0;
        tick();
        chk("tmo_issue", {tx_start_o, tx_sel_o, pending_o}, {1'b1, 2'd2, 4'b0001});
        early = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (timeout_err_o) early = 1'b1;
        end
        chk("tmo_not_early", 32'(early), 32'h0);
        chk("tmo_busy_wait", 32'(busy_o), 32'h1);
        tick();
        chk("tmo_pulse", 32'(timeout_err_o), 32'h1);
        tick();
        chk("tmo_one_cycle", 32'(timeout_err_o), 32'h0);
        tick();
        chk("tmo_idle", 32'(busy_o), 32'h0);
        tick();
        chk("tmo_next_grant", {tx_start_o, tx_sel_o, pending_o}, {1'b1, 2'd0, 4'b0000});
        finish_txn();

        // Set/clear collision on requester 0.
        enable_i    = 1'b0;
        req_pulse_i = 4'b0001;
        tick();
        enable_i = 1'b1;
        tick();
        chk("coll_issue", {tx_start_o, tx_sel_o, pending_o, req_ovf_o},
            {1'b1, 2'd0, 4'b0001, 4'b0000});
        req_pulse_i = '0;
        tick();
        chk("coll_no_ovf", 32'(req_ovf_o), 32'h0);
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        tick();
        tick();
        tick();
        chk("coll_regrant", {tx_start_o, tx_sel_o, pending_o}, {1'b1, 2'd0, 4'b0000});
        finish_txn();

        // Asynchronous reset while in WAIT with another request pending.
        req_pulse_i = 4'b0010;
        tick();
        req_pulse_i = '0;
        tick();
        chk("rst_pre_issue", {tx_start_o, tx_sel_o}, {1'b1, 2'd1});
        tick();
        req_pulse_i = 4'b1000;
        tick();
        req_pulse_i = '0;
        #3;
        rst_ni = 1'b0;
        #1;
        chk("rst_async_clear", 32'(obus), 32'h0);
        tick();
        tick();
        rst_ni = 1'b1;
        early  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (tx_start_o || busy_o || (pending_o != 0)) early = 1'b1;
        end
        chk("rst_quiet", 32'(early), 32'h0);
        req_pulse_i = 4'b0100;
        tick();
        req_pulse_i = '0;
        tick();
        chk("rst_new_grant", {tx_start_o, tx_sel_o}, {1'b1, 2'd2});
        finish_txn();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
